// File: rtl/note_detector_if.sv
// Tone input and decoded-note outputs of the note detector, bundled as one port.
interface note_detector_if;
  logic        tone_in;
  logic [1:0]  note_code;
  logic        note_valid;
  logic        note_change;
  logic [31:0] half_period;

  modport master (
    input  tone_in,
    output note_code, note_valid, note_change, half_period
  );

  modport slave (
    output tone_in,
    input  note_code, note_valid, note_change, half_period
  );
endinterface

// File: rtl/note_detector.sv
// Measures tone half-periods and locks DO/RE/MI after MATCH_COUNT agreeing measurements.
// Latency: outputs register 4 clk edges after a tone_in transition; no backpressure (levels and pulses).
module note_detector #(
  parameter int unsigned PW_DO           = 191113,
  parameter int unsigned PW_RE           = 170262,
  parameter int unsigned PW_MI           = 151685,
  parameter int unsigned TOL             = 2048,
  parameter int unsigned MATCH_COUNT     = 4,
  parameter int unsigned SILENCE_TIMEOUT = 400000
) (
  input logic             clk,
  input logic             reset_n,
  note_detector_if.master nd
);
  typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

  localparam logic [31:0] EXP_DO = 32'(PW_DO + 1);
  localparam logic [31:0] EXP_RE = 32'(PW_RE + 1);
  localparam logic [31:0] EXP_MI = 32'(PW_MI + 1);
  localparam logic [31:0] TOL32  = 32'(TOL);
  localparam logic [31:0] TOUT   = 32'(SILENCE_TIMEOUT);
  localparam logic [3:0]  MC     = 4'(MATCH_COUNT);

  state_t      state_q, state_d;
  logic [2:0]  sync_q;
  logic        edge_q;
  logic [31:0] hp_cnt_q, hp_cnt_d;
  logic [3:0]  match_q, match_d;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        change_q, change_d;
  logic        armed_q, armed_d;
  logic [31:0] half_q, half_d;
  logic [31:0] meas;
  logic [1:0]  cls;
  logic        timeout;

  function automatic logic in_win(input logic [31:0] m, input logic [31:0] e);
    logic [31:0] dev;
    dev = (m > e) ? (m - e) : (e - m);
    return dev <= TOL32;
  endfunction

  assign meas    = hp_cnt_q + 32'd1;
  assign timeout = !edge_q && (hp_cnt_q == TOUT - 32'd1);

  // DO wins over RE wins over MI if the tolerance windows ever overlap
  always_comb begin
    cls = 2'd0;
    if (in_win(meas, EXP_DO))      cls = 2'd1;
    else if (in_win(meas, EXP_RE)) cls = 2'd2;
    else if (in_win(meas, EXP_MI)) cls = 2'd3;
  end

  always_comb begin
    hp_cnt_d = hp_cnt_q;
    if (edge_q)               hp_cnt_d = 32'd0;
    else if (hp_cnt_q < TOUT) hp_cnt_d = hp_cnt_q + 32'd1;
  end

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    cand_d   = cand_q;
    code_d   = code_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    half_d   = half_q;
    armed_d  = armed_q;
    if (edge_q) begin
      if (!armed_q) begin
        armed_d = 1'b1;
      end else begin
        half_d = meas;
        case (state_q)
          HUNT: begin
            if (cls != 2'd0) begin
              state_d = ACQUIRE;
              cand_d  = cls;
              match_d = 4'd1;
            end
          end
          ACQUIRE: begin
            if (cls == 2'd0) begin
              state_d = HUNT;
              match_d = 4'd0;
            end else if (cls == cand_q) begin
              match_d = match_q + 4'd1;
              if (match_q + 4'd1 == MC) begin
                state_d  = LOCKED;
                code_d   = cand_q;
                valid_d  = 1'b1;
                change_d = (cand_q != code_q);
              end
            end else begin
              cand_d  = cls;
              match_d = 4'd1;
            end
          end
          LOCKED: begin
            if (cls == 2'd0) begin
              state_d = HUNT;
              match_d = 4'd0;
            end else if (cls != cand_q) begin
              state_d = ACQUIRE;
              cand_d  = cls;
              match_d = 4'd1;
            end
          end
          default: begin
            state_d = HUNT;
            match_d = 4'd0;
          end
        endcase
      end
    end else if (timeout) begin
      state_d  = HUNT;
      match_d  = 4'd0;
      armed_d  = 1'b0;
      code_d   = 2'd0;
      valid_d  = 1'b0;
      change_d = valid_q;
    end
  end

  // sync_q[1:0] is the synchronizer, sync_q[2] its delayed copy; edge_q registers the transition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 3'b000;
      edge_q   <= 1'b0;
      hp_cnt_q <= 32'd0;
      state_q  <= HUNT;
      match_q  <= 4'd0;
      cand_q   <= 2'd0;
      code_q   <= 2'd0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      armed_q  <= 1'b0;
      half_q   <= 32'd0;
    end else begin
      sync_q   <= {sync_q[1:0], nd.tone_in};
      edge_q   <= sync_q[1] ^ sync_q[2];
      hp_cnt_q <= hp_cnt_d;
      state_q  <= state_d;
      match_q  <= match_d;
      cand_q   <= cand_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      armed_q  <= armed_d;
      half_q   <= half_d;
    end
  end

  assign nd.note_code   = code_q;
  assign nd.note_valid  = valid_q;
  assign nd.note_change = change_q;
  assign nd.half_period = half_q;
endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector with scaled-down periods (DO=191, RE=161, MI=131 cycles, TOL=8, timeout=400).
module tb_note_detector;
  localparam int unsigned P_DO = 190;
  localparam int unsigned P_RE = 160;
  localparam int unsigned P_MI = 130;
  localparam int unsigned P_TOL = 8;
  localparam int unsigned P_MC = 4;
  localparam int unsigned P_TOUT = 400;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  note_detector_if nd_if();

  note_detector #(
    .PW_DO(P_DO), .PW_RE(P_RE), .PW_MI(P_MI), .TOL(P_TOL),
    .MATCH_COUNT(P_MC), .SILENCE_TIMEOUT(P_TOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .nd(nd_if.master)
  );

  typedef struct {
    bit rst;
    int hp;
    int n;
    int code;
    int valid;
    int chg;
    int hpo;
  } vec_t;

  vec_t tbl[15];
  int n_checks = 0;
  int n_fail = 0;
  int chg_cnt = 0;
  int since = 0;
  int base;

  always @(negedge clk) if (nd_if.note_change === 1'b1) chg_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic toggle_after(input int hp);
    int w;
    w = hp - since;
    if (w < 1) w = 1;
    repeat (w) @(posedge clk);
    #1 nd_if.tone_in = ~nd_if.tone_in;
    since = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    nd_if.tone_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    since = 0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    since = 6;
    #2;
  endtask

  task automatic run_row(input int idx);
    int b;
    if (tbl[idx].rst) do_reset();
    b = chg_cnt;
    for (int i = 0; i < tbl[idx].n; i++) toggle_after(tbl[idx].hp);
    settle();
    check($sformatf("row%0d note_code", idx), 32'(nd_if.note_code), tbl[idx].code);
    check($sformatf("row%0d note_valid", idx), 32'(nd_if.note_valid), tbl[idx].valid);
    check($sformatf("row%0d change_pulses", idx), chg_cnt - b, tbl[idx].chg);
    check($sformatf("row%0d half_period", idx), nd_if.half_period, tbl[idx].hpo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   hp   n  code valid chg  hp_out
    tbl[0]  = '{1'b1, 191, 4, 0, 0, 0, 191};
    tbl[1]  = '{1'b0, 191, 1, 1, 1, 1, 191};
    tbl[2]  = '{1'b0, 161, 3, 1, 1, 0, 161};
    tbl[3]  = '{1'b0, 161, 1, 2, 1, 1, 161};
    tbl[4]  = '{1'b0, 145, 1, 2, 1, 0, 145};
    tbl[5]  = '{1'b0, 131, 3, 2, 1, 0, 131};
    tbl[6]  = '{1'b0, 131, 1, 3, 1, 1, 131};
    tbl[7]  = '{1'b1, 199, 5, 1, 1, 1, 199};
    tbl[8]  = '{1'b1, 183, 5, 1, 1, 1, 183};
    tbl[9]  = '{1'b1, 200, 8, 0, 0, 0, 200};
    tbl[10] = '{1'b1, 182, 8, 0, 0, 0, 182};
    tbl[11] = '{1'b1, 191, 5, 1, 1, 1, 191};
    tbl[12] = '{1'b0, 145, 1, 1, 1, 0, 145};
    tbl[13] = '{1'b0, 191, 4, 1, 1, 0, 191};
    tbl[14] = '{1'b0, 400, 1, 1, 1, 0, 400};

    reset_n = 1'b1;
    nd_if.tone_in = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("reset note_code", 32'(nd_if.note_code), 0);
    check("reset note_valid", 32'(nd_if.note_valid), 0);
    check("reset note_change", 32'(nd_if.note_change), 0);
    check("reset half_period", nd_if.half_period, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int r = 0; r <= 6; r++) run_row(r);

    // Silence: outputs drop on clk edge T+4 after the last tone transition
    repeat (P_TOUT + 3 - 6) @(posedge clk);
    #2;
    check("silence before timeout valid", 32'(nd_if.note_valid), 1);
    check("silence before timeout code", 32'(nd_if.note_code), 3);
    base = chg_cnt;
    @(posedge clk);
    #2;
    check("silence timeout valid", 32'(nd_if.note_valid), 0);
    check("silence timeout code", 32'(nd_if.note_code), 0);
    repeat (50) @(posedge clk);
    #2;
    check("silence change pulses", chg_cnt - base, 1);
    @(posedge clk);
    #1 nd_if.tone_in = ~nd_if.tone_in;
    since = 0;
    settle();
    check("re-arm edge half_period", nd_if.half_period, 131);
    check("re-arm edge valid", 32'(nd_if.note_valid), 0);

    for (int r = 7; r <= 14; r++) run_row(r);

    // Reset while acquiring (match count 3) with a note still held from before
    for (int i = 0; i < 3; i++) toggle_after(191);
    repeat (6) @(posedge clk);
    #2;
    check("pre-reset note_valid", 32'(nd_if.note_valid), 1);
    #1 reset_n = 1'b0;
    nd_if.tone_in = 1'b0;
    #1;
    check("async reset note_code", 32'(nd_if.note_code), 0);
    check("async reset note_valid", 32'(nd_if.note_valid), 0);
    check("async reset half_period", nd_if.half_period, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    since = 0;
    base = chg_cnt;
    for (int i = 0; i < 4; i++) toggle_after(191);
    settle();
    check("post-reset edge4 valid", 32'(nd_if.note_valid), 0);
    check("post-reset edge4 code", 32'(nd_if.note_code), 0);
    toggle_after(191);
    settle();
    check("post-reset edge5 valid", 32'(nd_if.note_valid), 1);
    check("post-reset edge5 code", 32'(nd_if.note_code), 1);
    check("post-reset change pulses", chg_cnt - base, 1);
    check("post-reset half_period", nd_if.half_period, 191);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
